// File: rtl/dbus_pkg.sv
// Shared types and constants for the data-bus bridge: FSM states,
// kseg window bounds and the CPU byte-enable encodings.
package dbus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } dbus_state_t;

    localparam logic [31:0] KSEG_LO = 32'h8000_0000;
    localparam logic [31:0] KSEG_HI = 32'hBFFF_FFFF;

    localparam logic [3:0] BE_B = 4'b0001;
    localparam logic [3:0] BE_H = 4'b0011;
    localparam logic [3:0] BE_W = 4'b1111;

    function automatic logic is_kseg(input logic [31:0] addr);
        return (addr >= KSEG_LO) && (addr <= KSEG_HI);
    endfunction

endpackage

// File: rtl/dbus_bridge_if.sv
// CPU data-bus and split-handshake memory signals of the bridge.
// The slave modport is the bridge's view; master is the surrounding system.
interface dbus_bridge_if;

    logic        dbus_en;
    logic [3:0]  dbus_we;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_data;
    logic [31:0] dbus_rdata;
    logic        dbus_stall;
    logic        dbus_err;

    logic        mem_req;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    modport slave (
        input  dbus_en, dbus_we, dbus_addr, dbus_data,
        input  mem_addr_ok, mem_data_ok, mem_rdata,
        output dbus_rdata, dbus_stall, dbus_err,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output dbus_en, dbus_we, dbus_addr, dbus_data,
        output mem_addr_ok, mem_data_ok, mem_rdata,
        input  dbus_rdata, dbus_stall, dbus_err,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dbus_lane_align.sv
// Combinational store-lane shifter, kseg0/kseg1 address stripper and
// misalignment detector. Loads never fault here; extraction is downstream.
module dbus_lane_align
    import dbus_pkg::*;
#(
    parameter int unsigned MAP_KSEG = 1
) (
    input  logic [3:0]  we_i,
    input  logic [31:0] data_i,
    input  logic [31:0] addr_i,
    output logic [3:0]  we_o,
    output logic [31:0] wdata_o,
    output logic [31:0] addr_o,
    output logic        misaligned_o
);

    logic [1:0]  off;
    logic [31:0] mapped;

    always_comb begin
        off     = addr_i[1:0];
        we_o    = we_i << off;
        wdata_o = data_i << {off, 3'b000};

        mapped = addr_i;
        if ((MAP_KSEG != 0) && is_kseg(addr_i)) begin
            mapped[31:29] = 3'b000;
        end
        addr_o = {mapped[31:2], 2'b00};

        misaligned_o = 1'b0;
        if ((we_i == BE_H) && off[0]) begin
            misaligned_o = 1'b1;
        end
        if ((we_i == BE_W) && (off != 2'b00)) begin
            misaligned_o = 1'b1;
        end
    end

endmodule

// File: rtl/dbus_bridge.sv
// Responder for the CPU data bus: turns a single-cycle request into a
// req/addr_ok/data_ok memory transaction, stalling the pipeline until DONE.
module dbus_bridge
    import dbus_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 64,
    parameter int unsigned MAP_KSEG = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    dbus_bridge_if.slave  bus
);

    localparam int unsigned WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    dbus_state_t state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic [3:0]  mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [WD_W-1:0] wd_q, wd_d;

    logic [3:0]  al_we;
    logic [31:0] al_wdata;
    logic [31:0] al_addr;
    logic        al_mis;
    logic [WD_W-1:0] wd_inc;
    logic        timeout_hit;

    dbus_lane_align #(
        .MAP_KSEG (MAP_KSEG)
    ) u_align (
        .we_i         (bus.dbus_we),
        .data_i       (bus.dbus_data),
        .addr_i       (bus.dbus_addr),
        .we_o         (al_we),
        .wdata_o      (al_wdata),
        .addr_o       (al_addr),
        .misaligned_o (al_mis)
    );

    assign wd_inc      = wd_q + WD_W'(1);
    assign timeout_hit = (TIMEOUT != 0) && (wd_inc == WD_W'(TIMEOUT));

    // A response arriving in the same cycle the watchdog expires still completes.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        err_d       = 1'b0;
        wd_d        = wd_q;

        unique case (state_q)
            IDLE: begin
                if (bus.dbus_en) begin
                    if (al_mis) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d     = REQ;
                        mem_req_d   = 1'b1;
                        mem_we_d    = al_we;
                        mem_addr_d  = al_addr;
                        mem_wdata_d = al_wdata;
                        wd_d        = '0;
                    end
                end
            end
            REQ: begin
                wd_d = wd_inc;
                if (bus.mem_addr_ok && bus.mem_data_ok) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    rdata_d   = bus.mem_rdata;
                end else if (timeout_hit) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                end else if (bus.mem_addr_ok) begin
                    state_d   = WAIT;
                    mem_req_d = 1'b0;
                end
            end
            WAIT: begin
                wd_d = wd_inc;
                if (bus.mem_data_ok) begin
                    state_d = DONE;
                    rdata_d = bus.mem_rdata;
                end else if (timeout_hit) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            wd_q        <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            wd_q        <= wd_d;
        end
    end

    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.dbus_rdata = rdata_q;
    assign bus.dbus_err   = err_q;
    assign bus.dbus_stall = ((state_q == IDLE) && bus.dbus_en) ||
                            (state_q == REQ) || (state_q == WAIT);

endmodule

// File: tb/tb_dbus_bridge.sv
// Directed bench for dbus_bridge: store/load handshakes, misalignment,
// watchdog timeout, asynchronous reset abort and back-to-back accesses.
module tb_dbus_bridge;

    logic clk;
    logic rst_n;
    int unsigned errors;
    int unsigned checks;
    int unsigned acc_cnt;
    int unsigned acc_base;

    dbus_bridge_if bus ();

    dbus_bridge #(
        .TIMEOUT  (8),
        .MAP_KSEG (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && bus.mem_req && bus.mem_addr_ok) begin
            acc_cnt <= acc_cnt + 1;
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout observed=hang expected=finish");
        $fatal(1, "simulation time limit reached");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cpu(input logic en, input logic [3:0] we, input logic [31:0] addr,
                       input logic [31:0] data);
        bus.dbus_en   = en;
        bus.dbus_we   = we;
        bus.dbus_addr = addr;
        bus.dbus_data = data;
    endtask

    task automatic mem(input logic aok, input logic dok, input logic [31:0] rd);
        bus.mem_addr_ok = aok;
        bus.mem_data_ok = dok;
        bus.mem_rdata   = rd;
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        acc_cnt = 0;
        rst_n   = 1'b0;
        cpu(1'b0, 4'b0000, 32'h0, 32'h0);
        mem(1'b0, 1'b0, 32'h0);
        tick();
        tick();

        // Reset values
        chk("rst_mem_req",  {31'b0, bus.mem_req},    32'h0);
        chk("rst_mem_we",   {28'b0, bus.mem_we},     32'h0);
        chk("rst_mem_addr", bus.mem_addr,            32'h0);
        chk("rst_wdata",    bus.mem_wdata,           32'h0);
        chk("rst_rdata",    bus.dbus_rdata,          32'h0);
        chk("rst_err",      {31'b0, bus.dbus_err},   32'h0);
        chk("rst_stall",    {31'b0, bus.dbus_stall}, 32'h0);
        rst_n = 1'b1;
        tick();

        // Store byte into kseg0, same-cycle addr_ok + data_ok
        cpu(1'b1, 4'b0001, 32'h8000_0013, 32'h0000_00AB);
        #1;
        chk("sb_stall_c0", {31'b0, bus.dbus_stall}, 32'h1);
        tick();
        chk("sb_req",   {31'b0, bus.mem_req},    32'h1);
        chk("sb_addr",  bus.mem_addr,            32'h0000_0010);
        chk("sb_we",    {28'b0, bus.mem_we},     32'h8);
        chk("sb_wdata", bus.mem_wdata,           32'hAB00_0000);
        chk("sb_stall_c1", {31'b0, bus.dbus_stall}, 32'h1);
        mem(1'b1, 1'b1, 32'h1122_3344);
        tick();
        chk("sb_done_stall", {31'b0, bus.dbus_stall}, 32'h0);
        chk("sb_done_err",   {31'b0, bus.dbus_err},   32'h0);
        chk("sb_done_req",   {31'b0, bus.mem_req},    32'h0);
        cpu(1'b0, 4'b0000, 32'h0, 32'h0);
        mem(1'b0, 1'b0, 32'h0);
        tick();
        chk("sb_idle_stall", {31'b0, bus.dbus_stall}, 32'h0);

        // Load from kseg1, addr_ok at cycle 3, data_ok at cycle 6
        cpu(1'b1, 4'b0000, 32'hA000_0100, 32'h0);
        tick();
        chk("ld_req_c1", {31'b0, bus.mem_req}, 32'h1);
        chk("ld_addr",   bus.mem_addr,         32'h0000_0100);
        chk("ld_we",     {28'b0, bus.mem_we},  32'h0);
        tick();
        chk("ld_req_c2", {31'b0, bus.mem_req}, 32'h1);
        tick();
        mem(1'b1, 1'b0, 32'h0);
        tick();
        mem(1'b0, 1'b0, 32'h0);
        chk("ld_wait_req",   {31'b0, bus.mem_req},    32'h0);
        chk("ld_wait_stall", {31'b0, bus.dbus_stall}, 32'h1);
        tick();
        chk("ld_stall_c5", {31'b0, bus.dbus_stall}, 32'h1);
        tick();
        mem(1'b0, 1'b1, 32'hDEAD_BEEF);
        chk("ld_stall_c6", {31'b0, bus.dbus_stall}, 32'h1);
        tick();
        chk("ld_rdata",      bus.dbus_rdata,          32'hDEAD_BEEF);
        chk("ld_done_stall", {31'b0, bus.dbus_stall}, 32'h0);
        chk("ld_done_err",   {31'b0, bus.dbus_err},   32'h0);
        cpu(1'b0, 4'b0000, 32'h0, 32'h0);
        mem(1'b0, 1'b0, 32'h0);
        tick();

        // Misaligned store word: no request, one-cycle error pulse
        cpu(1'b1, 4'b1111, 32'h0000_0102, 32'h5555_5555);
        #1;
        chk("sw_mis_stall_c0", {31'b0, bus.dbus_stall}, 32'h1);
        tick();
        chk("sw_mis_req",   {31'b0, bus.mem_req},    32'h0);
        chk("sw_mis_err",   {31'b0, bus.dbus_err},   32'h1);
        chk("sw_mis_stall", {31'b0, bus.dbus_stall}, 32'h0);
        cpu(1'b0, 4'b0000, 32'h0, 32'h0);
        tick();
        chk("sw_mis_err_clr", {31'b0, bus.dbus_err}, 32'h0);
        chk("sw_mis_req_c2",  {31'b0, bus.mem_req},  32'h0);

        // Watchdog: addr_ok but no data_ok, expiry after 8 REQ/WAIT cycles
        cpu(1'b1, 4'b0000, 32'h0000_0200, 32'h0);
        tick();
        chk("to_req", {31'b0, bus.mem_req}, 32'h1);
        mem(1'b1, 1'b0, 32'h0);
        tick();
        mem(1'b0, 1'b0, 32'h0);
        for (int i = 3; i <= 8; i++) begin
            tick();
            chk($sformatf("to_stall_c%0d", i), {31'b0, bus.dbus_stall}, 32'h1);
            chk($sformatf("to_err_c%0d", i),   {31'b0, bus.dbus_err},   32'h0);
        end
        tick();
        chk("to_err",   {31'b0, bus.dbus_err},   32'h1);
        chk("to_stall", {31'b0, bus.dbus_stall}, 32'h0);
        chk("to_req_0", {31'b0, bus.mem_req},    32'h0);
        cpu(1'b0, 4'b0000, 32'h0, 32'h0);
        tick();
        mem(1'b0, 1'b1, 32'hBAD0_BAD0);
        chk("to_err_clr", {31'b0, bus.dbus_err}, 32'h0);
        tick();
        mem(1'b0, 1'b0, 32'h0);
        chk("to_late_rdata", bus.dbus_rdata,          32'hDEAD_BEEF);
        chk("to_late_stall", {31'b0, bus.dbus_stall}, 32'h0);
        chk("to_late_err",   {31'b0, bus.dbus_err},   32'h0);
        cpu(1'b1, 4'b0000, 32'h0000_0300, 32'h0);
        tick();
        chk("to_new_req",  {31'b0, bus.mem_req}, 32'h1);
        chk("to_new_addr", bus.mem_addr,         32'h0000_0300);
        mem(1'b1, 1'b1, 32'hCAFE_F00D);
        tick();
        chk("to_new_rdata", bus.dbus_rdata,        32'hCAFE_F00D);
        chk("to_new_err",   {31'b0, bus.dbus_err}, 32'h0);
        cpu(1'b0, 4'b0000, 32'h0, 32'h0);
        mem(1'b0, 1'b0, 32'h0);
        tick();

        // Asynchronous reset while in WAIT
        cpu(1'b1, 4'b0000, 32'h0000_0400, 32'h0);
        tick();
        mem(1'b1, 1'b0, 32'h0);
        tick();
        mem(1'b0, 1'b0, 32'h0);
        chk("ar_wait_stall", {31'b0, bus.dbus_stall}, 32'h1);
        chk("ar_wait_addr",  bus.mem_addr,            32'h0000_0400);
        #2;
        rst_n = 1'b0;
        cpu(1'b0, 4'b0000, 32'h0, 32'h0);
        #1;
        chk("ar_req",   {31'b0, bus.mem_req},    32'h0);
        chk("ar_stall", {31'b0, bus.dbus_stall}, 32'h0);
        chk("ar_addr",  bus.mem_addr,            32'h0);
        chk("ar_rdata", bus.dbus_rdata,          32'h0);
        tick();
        rst_n = 1'b1;
        mem(1'b0, 1'b1, 32'h1234_5678);
        tick();
        mem(1'b0, 1'b0, 32'h0);
        chk("ar_stray_rdata", bus.dbus_rdata,          32'h0);
        chk("ar_stray_stall", {31'b0, bus.dbus_stall}, 32'h0);
        chk("ar_stray_err",   {31'b0, bus.dbus_err},   32'h0);
        chk("ar_stray_req",   {31'b0, bus.mem_req},    32'h0);
        tick();

        // Back-to-back: SH at 0x2, then a load presented right after DONE
        acc_base = acc_cnt;
        cpu(1'b1, 4'b0011, 32'h0000_0002, 32'h0000_1234);
        tick();
        chk("b2b_sh_req",   {31'b0, bus.mem_req}, 32'h1);
        chk("b2b_sh_we",    {28'b0, bus.mem_we},  32'hC);
        chk("b2b_sh_wdata", bus.mem_wdata,        32'h1234_0000);
        chk("b2b_sh_addr",  bus.mem_addr,         32'h0);
        mem(1'b1, 1'b1, 32'h0);
        tick();
        chk("b2b_done_stall", {31'b0, bus.dbus_stall}, 32'h0);
        chk("b2b_done_req",   {31'b0, bus.mem_req},    32'h0);
        chk("b2b_done_err",   {31'b0, bus.dbus_err},   32'h0);
        mem(1'b0, 1'b0, 32'h0);
        cpu(1'b1, 4'b0000, 32'h0000_0008, 32'h0);
        tick();
        chk("b2b_idle_stall", {31'b0, bus.dbus_stall}, 32'h1);
        chk("b2b_idle_req",   {31'b0, bus.mem_req},    32'h0);
        tick();
        chk("b2b_ld_req",  {31'b0, bus.mem_req}, 32'h1);
        chk("b2b_ld_we",   {28'b0, bus.mem_we},  32'h0);
        chk("b2b_ld_addr", bus.mem_addr,         32'h0000_0008);
        mem(1'b1, 1'b1, 32'h55AA_55AA);
        tick();
        chk("b2b_ld_rdata", bus.dbus_rdata, 32'h55AA_55AA);
        cpu(1'b0, 4'b0000, 32'h0, 32'h0);
        mem(1'b0, 1'b0, 32'h0);
        tick();
        tick();
        chk("b2b_end_req",   {31'b0, bus.mem_req},    32'h0);
        chk("b2b_end_stall", {31'b0, bus.dbus_stall}, 32'h0);
        chk("b2b_accepts",   acc_cnt - acc_base,      32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
